// File: rtl/lif_integrator.sv
// Leaky integrate-and-fire stage fed by plastic_neuron output_signal.
// Optional teacher feedback path enabled by LIF_ERROR_FEEDBACK_EN.
module lif_integrator #(
  parameter logic signed [31:0] THRESHOLD      = 32'sd65536,
  parameter int unsigned        LEAK_SHIFT     = 4,
  parameter int unsigned        REFRACT_CYCLES = 8,
  parameter logic signed [15:0] ERR_MAG        = 16'sd32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [31:0] in_data,
  output logic               in_ready,
  input  logic               target_spike,
  output logic               spike,
  output logic signed [31:0] membrane,
  output logic [15:0]        spike_count,
  output logic signed [15:0] feedback_error,
  output logic               learn_en
);

  localparam int CW =
    (REFRACT_CYCLES < 2) ? 1 : $clog2(REFRACT_CYCLES + 1);
  localparam logic [CW-1:0] RC = CW'(REFRACT_CYCLES);
  localparam logic signed [33:0] THR =
    {{2{THRESHOLD[31]}}, THRESHOLD};
  localparam logic signed [33:0] FLOOR = -THR;

  typedef enum logic {
    S_INTEG,
    S_REFRACT
  } state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic signed [31:0] mem_n;
  logic               spike_n;
  logic [15:0]        count_n;
  logic signed [15:0] ferr_n;
  logic               learn_n;

  logic               accept;
  logic               fire;
  logic signed [33:0] mem34;
  logic signed [33:0] leak;
  logic signed [33:0] m;

  assign in_ready = 1'b1;
  assign accept   = in_valid & in_ready;

  assign mem34 = {{2{membrane[31]}}, membrane};
  assign leak  = mem34 >>> LEAK_SHIFT;
  assign m     = mem34 - leak + {{2{in_data[31]}}, in_data};
  assign fire  = (state == S_INTEG) && accept && (m >= THR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_INTEG;
      cnt            <= '0;
      membrane       <= '0;
      spike          <= 1'b0;
      spike_count    <= '0;
      feedback_error <= '0;
      learn_en       <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      membrane       <= mem_n;
      spike          <= spike_n;
      spike_count    <= count_n;
      feedback_error <= ferr_n;
      learn_en       <= learn_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mem_n   = membrane;
    spike_n = 1'b0;
    count_n = spike_count;
    unique case (state)
      S_INTEG: begin
        if (fire) begin
          spike_n = 1'b1;
          mem_n   = '0;
          if (spike_count != 16'hFFFF)
            count_n = spike_count + 16'd1;
          if (REFRACT_CYCLES != 0) begin
            state_n = S_REFRACT;
            cnt_n   = RC;
          end
        end else if (accept) begin
          if (m < FLOOR)
            mem_n = FLOOR[31:0];
          else
            mem_n = m[31:0];
        end
      end
      S_REFRACT: begin
        // samples arriving here are consumed and dropped
        mem_n = '0;
        if (cnt != '0)
          cnt_n = cnt - 1'b1;
        if (cnt <= 1)
          state_n = S_INTEG;
      end
      default: begin
        state_n = S_INTEG;
        cnt_n   = '0;
        mem_n   = '0;
      end
    endcase
  end

`ifdef LIF_ERROR_FEEDBACK_EN
  always_comb begin
    ferr_n  = '0;
    learn_n = 1'b0;
    if (state == S_INTEG && accept) begin
      if (target_spike && !fire) begin
        ferr_n  = ERR_MAG;
        learn_n = 1'b1;
      end else if (!target_spike && fire) begin
        ferr_n  = -ERR_MAG;
        learn_n = 1'b1;
      end
    end
  end
`else
  logic unused_target;
  assign unused_target = target_spike;
  assign ferr_n  = '0;
  assign learn_n = 1'b0;
`endif

endmodule

// File: tb/tb_lif_integrator.sv
// Directed bench for lif_integrator with a pop-on-output scoreboard.
// Feedback expectations follow LIF_ERROR_FEEDBACK_EN.
module tb_lif_integrator;

`ifdef LIF_ERROR_FEEDBACK_EN
  localparam bit FB = 1'b1;
`else
  localparam bit FB = 1'b0;
`endif

  localparam logic signed [31:0] MIN32 = 32'sh8000_0000;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [31:0] in_data;
  logic               in_ready;
  logic               target_spike;
  logic               spike;
  logic signed [31:0] membrane;
  logic [15:0]        spike_count;
  logic signed [15:0] feedback_error;
  logic               learn_en;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string              tag;
    logic               sp;
    logic signed [31:0] mem;
    logic [15:0]        cnt;
    logic signed [15:0] fe;
    logic               le;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  lif_integrator #(
    .THRESHOLD     (32'sd1000),
    .LEAK_SHIFT    (4),
    .REFRACT_CYCLES(3),
    .ERR_MAG       (16'sd32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .target_spike  (target_spike),
    .spike         (spike),
    .membrane      (membrane),
    .spike_count   (spike_count),
    .feedback_error(feedback_error),
    .learn_en      (learn_en)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic v,
                      input logic signed [31:0] d, input logic t,
                      input logic esp, input logic signed [31:0] emem,
                      input logic [15:0] ecnt,
                      input logic signed [15:0] efe, input logic ele);
    exp_t e;
    exp_t g;
    in_valid     = v;
    in_data      = d;
    target_spike = t;
    e.tag = tag;
    e.sp  = esp;
    e.mem = emem;
    e.cnt = ecnt;
    e.fe  = efe;
    e.le  = ele;
    sbq.push_back(e);
    if (!rst)
      chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    chk({g.tag, ".spike"}, 32'(spike), 32'(g.sp));
    chk({g.tag, ".mem"}, membrane, g.mem);
    chk({g.tag, ".count"}, 32'(spike_count), 32'(g.cnt));
    chk({g.tag, ".ferr"}, 32'(feedback_error), 32'(g.fe));
    chk({g.tag, ".learn"}, 32'(learn_en), 32'(g.le));
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    target_spike = 1'b0;

    do_reset(2);
    chk("rst.mem", membrane, 32'd0);
    chk("rst.spike", 32'(spike), 32'd0);
    chk("rst.count", 32'(spike_count), 32'd0);
    chk("rst.learn", 32'(learn_en), 32'd0);
    chk("rst.ferr", 32'(feedback_error), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd1);

    step("leak0", 1, 512, 0, 0, 512, 0, 0, 0);
    step("leak1", 1, 0, 0, 0, 480, 0, 0, 0);
    step("leak2", 1, 0, 0, 0, 450, 0, 0, 0);
    step("idle", 0, 5000, 0, 0, 450, 0, 0, 0);

    step("fire1", 1, 1200, 1, 1, 0, 1, 0, 0);
    step("drop0", 1, 5000, 1, 0, 0, 1, 0, 0);
    step("drop1", 1, 5000, 1, 0, 0, 1, 0, 0);
    step("drop2", 1, 5000, 1, 0, 0, 1, 0, 0);
    step("fire2", 1, 5000, 1, 1, 0, 2, 0, 0);
    step("ref0", 0, 0, 0, 0, 0, 2, 0, 0);
    step("ref1", 0, 0, 0, 0, 0, 2, 0, 0);
    step("ref2", 0, 0, 0, 0, 0, 2, 0, 0);

    step("floor0", 1, MIN32, 0, 0, -1000, 2, 0, 0);
    step("floor1", 1, MIN32, 0, 0, -1000, 2, 0, 0);
    step("floor2", 1, MIN32, 0, 0, -1000, 2, 0, 0);

    do_reset(1);
    chk("rst2.count", 32'(spike_count), 32'd0);
    step("fb_pos", 1, 100, 1, 0, 100, 0,
         FB ? 16'sd32 : 16'sd0, FB);
    step("fb_clr", 0, 0, 1, 0, 100, 0, 0, 0);
    step("fb_neg", 1, 1200, 0, 1, 0, 1,
         FB ? -16'sd32 : 16'sd0, FB);
    step("fb_ref0", 0, 0, 0, 0, 0, 1, 0, 0);
    step("fb_ref1", 0, 0, 0, 0, 0, 1, 0, 0);
    step("fb_ref2", 0, 0, 0, 0, 0, 1, 0, 0);
    step("fb_hit", 1, 1200, 1, 1, 0, 2, 0, 0);

    step("rr_ref0", 0, 0, 0, 0, 0, 2, 0, 0);
    rst = 1'b1;
    step("rr_rst", 1, 1200, 1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step("rr_fire", 1, 1200, 1, 1, 0, 1, 0, 0);

    chk("sb.empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
